// File: rtl/cache_ctrl.sv
// Control FSM for a direct-mapped L1 data cache: hit/miss, dirty write-back, line refill.
// cache_req_o = {index, wr_en}; tag words = {valid, dirty, tag}. CACHE_STATS_EN adds hit/miss counters.
module cache_ctrl #(
  parameter int  ADDR_W   = 32,
  parameter int  INDEX_W  = 8,
  parameter int  OFFSET_W = 4,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cpu_req_valid_i,
  output logic               cpu_req_ready_o,
  input  logic               cpu_we_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  output logic               cpu_rsp_valid_o,
  output logic [INDEX_W:0]   cache_req_o,
  output logic [TAG_W+1:0]   wr_tag_o,
  input  logic [TAG_W+1:0]   rd_tag_i,
  output logic               data_hit_we_o,
  output logic               data_refill_we_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic               mem_req_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic               mem_rsp_valid_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE, COMPARE, WRITEBACK, WB_WAIT, ALLOCATE, REFILL_WAIT
  } state_t;

  state_t             state, state_nxt;
  logic [INDEX_W-1:0] lat_index;
  logic [TAG_W-1:0]   lat_tag;
  logic               lat_we;
  logic [TAG_W-1:0]   victim_tag;
  logic               recheck;

  logic [INDEX_W-1:0] cpu_index;
  logic [TAG_W-1:0]   cpu_tag;
  logic               rd_valid, rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  logic               hit;
  logic               tag_we;
  logic [INDEX_W-1:0] req_index;
  logic               unused_offset;

  assign cpu_index     = cpu_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign cpu_tag       = cpu_addr_i[ADDR_W-1:ADDR_W-TAG_W];
  assign unused_offset = ^cpu_addr_i[OFFSET_W-1:0];
  assign rd_valid      = rd_tag_i[TAG_W+1];
  assign rd_dirty      = rd_tag_i[TAG_W];
  assign rd_tag        = rd_tag_i[TAG_W-1:0];
  assign hit           = rd_valid && (rd_tag == lat_tag);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      lat_index  <= '0;
      lat_tag    <= '0;
      lat_we     <= 1'b0;
      victim_tag <= '0;
      recheck    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cpu_req_valid_i) begin
        lat_index <= cpu_index;
        lat_tag   <= cpu_tag;
        lat_we    <= cpu_we_i;
      end
      // Hold the victim tag so the write-back address cannot move while stalled.
      if (state == COMPARE && !hit)
        victim_tag <= rd_tag;
      if (state == REFILL_WAIT && mem_rsp_valid_i)
        recheck <= 1'b1;
      else if (state == COMPARE)
        recheck <= 1'b0;
    end
  end

  always_comb begin
    state_nxt        = state;
    cpu_req_ready_o  = 1'b0;
    cpu_rsp_valid_o  = 1'b0;
    tag_we           = 1'b0;
    wr_tag_o         = '0;
    data_hit_we_o    = 1'b0;
    data_refill_we_o = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_req_we_o     = 1'b0;
    mem_addr_o       = '0;
    req_index        = lat_index;
    case (state)
      IDLE: begin
        cpu_req_ready_o = ~rst_i;
        req_index       = cpu_index;
        if (cpu_req_valid_i)
          state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_rsp_valid_o = 1'b1;
          if (lat_we) begin
            data_hit_we_o = 1'b1;
            tag_we        = 1'b1;
            wr_tag_o      = {1'b1, 1'b1, lat_tag};
          end
          state_nxt = IDLE;
        end else if (rd_valid && rd_dirty) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_addr_o      = {victim_tag, lat_index, {OFFSET_W{1'b0}}};
        if (mem_req_ready_i)
          state_nxt = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem_rsp_valid_i)
          state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = {lat_tag, lat_index, {OFFSET_W{1'b0}}};
        if (mem_req_ready_i)
          state_nxt = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (mem_rsp_valid_i) begin
          data_refill_we_o = 1'b1;
          tag_we           = 1'b1;
          wr_tag_o         = {1'b1, 1'b0, lat_tag};
          state_nxt        = COMPARE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    cache_req_o = rst_i ? '0 : {req_index, tag_we};
  end

`ifdef CACHE_STATS_EN
  // Only the first-pass lookup counts; the post-refill re-check is bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (state == COMPARE && !recheck) begin
      if (hit && hit_cnt_o != 32'hFFFF_FFFF)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      else if (!hit && miss_cnt_o != 32'hFFFF_FFFF)
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule
